// File: rtl/flex_fifo_fwft_if.sv
// Producer/consumer handshake bundle for flex_fifo_fwft.
// The slave modport is the FIFO side; the master modport is the attached engine(s).
interface flex_fifo_fwft_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_wr_en;
  logic                  o_full;
  logic                  o_afull;
  logic                  o_overflow;
  logic                  i_rd_en;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_valid;
  logic                  o_empty;
  logic                  o_aempty;
  logic                  o_underflow;

  modport slave (
    input  i_wr_data, i_wr_en, i_rd_en,
    output o_full, o_afull, o_overflow,
    output o_rd_data, o_rd_valid, o_empty, o_aempty, o_underflow
  );

  modport master (
    output i_wr_data, i_wr_en, i_rd_en,
    input  o_full, o_afull, o_overflow,
    input  o_rd_data, o_rd_valid, o_empty, o_aempty, o_underflow
  );
endinterface

// File: rtl/flex_fifo_fwft.sv
// Synchronous FIFO with registered-read or first-word-fall-through output,
// programmable almost flags, flush, sticky error flags and a high-water mark.
module flex_fifo_fwft #(
  parameter int  DATA_WIDTH = 16,
  parameter int  DEPTH      = 128,
  parameter int  FWFT       = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_clr_status,
  input  logic [AW:0]     i_afull_thresh,
  input  logic [AW:0]     i_aempty_thresh,
  output logic [AW:0]     o_count,
  output logic [AW:0]     o_max_count,
  flex_fifo_fwft_if.slave io_bus
);

  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [AW:0]           r_max_count;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic [AW:0]           w_ram_cnt;
  logic                  w_mem_rd;
  logic                  w_valid_nxt;
  logic                  w_empty_nxt;
  logic [AW:0]           w_count_nxt;
  logic [AW:0]           w_max_nxt;

  // Acceptance, error events and post-update state for the next edge.
  always_comb begin
    w_wr_acc    = io_bus.i_wr_en && !r_full  && !i_flush;
    w_rd_acc    = io_bus.i_rd_en && !r_empty && !i_flush;
    w_ovf_evt   = io_bus.i_wr_en && r_full   && !i_flush;
    w_udf_evt   = io_bus.i_rd_en && r_empty  && !i_flush;
    w_ram_cnt   = r_count;
    w_mem_rd    = 1'b0;
    w_valid_nxt = 1'b0;
    w_empty_nxt = 1'b1;
    w_count_nxt = r_count;
    w_max_nxt   = r_max_count;

    // In FWFT mode the output register holds one of the counted words, and it
    // is refilled from RAM whenever it is empty or being popped.
    if (FWFT != 0) begin
      w_ram_cnt = r_count - {{AW{1'b0}}, r_rd_valid};
      w_mem_rd  = (w_ram_cnt != CNT_ZERO) && (!r_rd_valid || w_rd_acc) && !i_flush;
      if (i_flush) begin
        w_valid_nxt = 1'b0;
      end else if (w_mem_rd) begin
        w_valid_nxt = 1'b1;
      end else if (w_rd_acc) begin
        w_valid_nxt = 1'b0;
      end else begin
        w_valid_nxt = r_rd_valid;
      end
    end else begin
      w_mem_rd    = w_rd_acc;
      w_valid_nxt = w_rd_acc;
    end

    if (i_flush) begin
      w_count_nxt = CNT_ZERO;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + CNT_ONE;
        2'b01:   w_count_nxt = r_count - CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end

    if (FWFT != 0) begin
      w_empty_nxt = !w_valid_nxt;
    end else begin
      w_empty_nxt = (w_count_nxt == CNT_ZERO);
    end

    if (i_clr_status) begin
      w_max_nxt = w_count_nxt;
    end else if (w_count_nxt > r_max_count) begin
      w_max_nxt = w_count_nxt;
    end else begin
      w_max_nxt = r_max_count;
    end
  end

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= io_bus.i_wr_data;
    end
  end

  // Pointers, count, flags and the read-side output register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr    <= PTR_ZERO;
      r_rd_ptr    <= PTR_ZERO;
      r_count     <= CNT_ZERO;
      r_max_count <= CNT_ZERO;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= {DATA_WIDTH{1'b0}};
    end else begin
      if (i_flush) begin
        r_wr_ptr <= PTR_ZERO;
      end else if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_flush) begin
        r_rd_ptr <= PTR_ZERO;
      end else if (w_mem_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_mem_rd) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_count     <= w_count_nxt;
      r_max_count <= w_max_nxt;
      r_full      <= (w_count_nxt == CNT_DEPTH);
      r_afull     <= (w_count_nxt >= i_afull_thresh);
      r_aempty    <= (w_count_nxt <= i_aempty_thresh);
      r_empty     <= w_empty_nxt;
      r_rd_valid  <= w_valid_nxt;
      // A new error in the clearing cycle keeps its flag set.
      r_overflow  <= (r_overflow  && !i_clr_status) || w_ovf_evt;
      r_underflow <= (r_underflow && !i_clr_status) || w_udf_evt;
    end
  end

  assign o_count            = r_count;
  assign o_max_count        = r_max_count;
  assign io_bus.o_full      = r_full;
  assign io_bus.o_afull     = r_afull;
  assign io_bus.o_overflow  = r_overflow;
  assign io_bus.o_rd_data   = r_rd_data;
  assign io_bus.o_rd_valid  = r_rd_valid;
  assign io_bus.o_empty     = r_empty;
  assign io_bus.o_aempty    = r_aempty;
  assign io_bus.o_underflow = r_underflow;

endmodule
